// File: rtl/pixel_buffer_ctrl.sv
// pixel_buffer_ctrl: captures one complete active video frame into a
// single-port pixel BRAM and lets readers use the same port in any cycle
// the capture is not writing. Writes always win over reads.
module pixel_buffer_ctrl #(
    parameter int ADDR_W     = 12,
    parameter int DEPTH      = 4096,
    parameter int VBLANK_MIN = 64
) (
    input  logic              PixelClk,
    input  logic              aRst,
    input  logic              aPixelClkLckd,
    input  logic              pVDE,
    input  logic [23:0]       pData,
    input  logic              arm,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   pix_count,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [23:0]       rd_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [23:0]       bram_wdata,
    input  logic [23:0]       bram_rdata
);

    localparam int LO_W = $clog2(VBLANK_MIN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_VBLANK, S_WAIT_FRAME, S_CAPTURE, S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_lck_meta, r_lck_s;
    logic [LO_W-1:0]   r_lo_cnt;
    logic [ADDR_W:0]   r_pix_count;
    logic              r_busy, r_done, r_ovf;
    logic              r_bram_en, r_bram_we;
    logic [ADDR_W-1:0] r_bram_addr;
    logic [23:0]       r_bram_wdata;
    logic              r_rd_pend, r_rd_valid;

    logic w_vblank, w_full, w_wr, w_ovf, w_arm_ok, w_abort, w_rd_ack;

    // A long enough run of blank cycles marks the vertical blank; a full
    // buffer means the next active pixel has nowhere to go.
    assign w_vblank = (r_lo_cnt == LO_W'(VBLANK_MIN));
    assign w_full   = (r_pix_count == (ADDR_W+1)'(DEPTH));

    // Lock indication is asynchronous to PixelClk; two flops before use.
    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            r_lck_meta <= 1'b0;
            r_lck_s    <= 1'b0;
        end else begin
            r_lck_meta <= aPixelClkLckd;
            r_lck_s    <= r_lck_meta;
        end
    end

    // Saturating count of consecutive blank cycles, running in all states.
    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst)
            r_lo_cnt <= '0;
        else if (pVDE)
            r_lo_cnt <= '0;
        else if (!w_vblank)
            r_lo_cnt <= r_lo_cnt + 1'b1;
    end

    // Next-state logic plus the per-cycle write/overflow/abort decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_ovf       = 1'b0;
        w_arm_ok    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (arm && r_lck_s) begin
                    w_arm_ok    = 1'b1;
                    w_state_nxt = S_WAIT_VBLANK;
                end
            end
            S_WAIT_VBLANK: begin
                if (!r_lck_s) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_vblank) begin
                    w_state_nxt = S_WAIT_FRAME;
                end
            end
            S_WAIT_FRAME: begin
                if (!r_lck_s) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (pVDE) begin
                    w_wr        = 1'b1;
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // A pixel arriving just as the blank completes belongs to
                // the next frame, so end-of-frame is checked before writing.
                if (!r_lck_s) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_vblank) begin
                    w_state_nxt = S_DONE;
                end else if (pVDE) begin
                    if (w_full) begin
                        w_ovf       = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_wr = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_rd_ack = rd_req & ~w_wr;

    // State register and the status flags that move with it.
    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_pix_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_WAIT_VBLANK) ||
                       (w_state_nxt == S_WAIT_FRAME)  ||
                       (w_state_nxt == S_CAPTURE);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_arm_ok || w_abort)
                r_ovf <= 1'b0;
            else if (w_ovf)
                r_ovf <= 1'b1;
            if (w_arm_ok)
                r_pix_count <= '0;
            else if (w_wr)
                r_pix_count <= r_pix_count + 1'b1;
        end
    end

    // Registered BRAM port: a capture write or an acked read, never both.
    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            r_bram_en    <= 1'b0;
            r_bram_we    <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_wdata <= '0;
        end else begin
            r_bram_en    <= w_wr | w_rd_ack;
            r_bram_we    <= w_wr;
            r_bram_addr  <= w_wr ? r_pix_count[ADDR_W-1:0] : rd_addr;
            r_bram_wdata <= w_wr ? pData : '0;
        end
    end

    // Read return tracking: BRAM data lands two cycles after the ack.
    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_pend  <= w_rd_ack;
            r_rd_valid <= r_rd_pend;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_ovf;
    assign pix_count  = r_pix_count;
    assign rd_ack     = w_rd_ack;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_valid ? bram_rdata : '0;
    assign bram_en    = r_bram_en;
    assign bram_we    = r_bram_we;
    assign bram_addr  = r_bram_addr;
    assign bram_wdata = r_bram_wdata;

endmodule
